// File: rtl/spi_sram_pkg.sv
// rtl/spi_sram_pkg.sv - opcodes, FSM states and mode encodings shared by the SPI SRAM target
package spi_sram_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WRSR  = 8'h01;

  localparam logic [1:0] MODE_BYTE  = 2'b00;
  localparam logic [1:0] MODE_SEQ   = 2'b01;
  localparam logic [1:0] MODE_PAGE  = 2'b10;
  localparam logic [7:0] MODE_RESET = 8'h40;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    RD_DATA,
    WR_DATA,
    IGNORE,
    STATUS
  } state_t;

  function automatic logic is_mem_op(input logic [7:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

  function automatic logic is_status_op(input logic [7:0] op);
    return (op == OP_RDSR) || (op == OP_WRSR);
  endfunction

endpackage

// File: rtl/spi_sram_if.sv
// rtl/spi_sram_if.sv - single-port memory bus between the SPI SRAM target and on-chip RAM
interface spi_sram_if #(
  parameter int MEM_AW = 12
);
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd_en;
  logic [7:0]        mem_rdata;
  logic              mem_wr_en;
  logic [7:0]        mem_wdata;

  modport master (
    output mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - synchronizers for sclk/cs/mosi plus single-clk edge pulses
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs,
  input  logic mosi,
  output logic cs_s,
  output logic mosi_s,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_rise,
  output logic cs_fall
);

  logic [SYNC_STAGES-1:0] sclk_ff, cs_ff, mosi_ff;
  logic                   sclk_d, cs_d;

  // cs chain resets low: a cs held low across reset must not look like a new cs fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_ff <= '0;
      cs_ff   <= '0;
      mosi_ff <= '0;
      sclk_d  <= 1'b0;
      cs_d    <= 1'b0;
    end else begin
      sclk_ff <= {sclk_ff[SYNC_STAGES-2:0], sclk};
      cs_ff   <= {cs_ff[SYNC_STAGES-2:0], cs};
      mosi_ff <= {mosi_ff[SYNC_STAGES-2:0], mosi};
      sclk_d  <= sclk_ff[SYNC_STAGES-1];
      cs_d    <= cs_ff[SYNC_STAGES-1];
    end
  end

  assign cs_s      = cs_ff[SYNC_STAGES-1];
  assign mosi_s    = mosi_ff[SYNC_STAGES-1];
  assign sclk_rise =  sclk_ff[SYNC_STAGES-1] & ~sclk_d;
  assign sclk_fall = ~sclk_ff[SYNC_STAGES-1] &  sclk_d;
  assign cs_rise   =  cs_ff[SYNC_STAGES-1] & ~cs_d;
  assign cs_fall   = ~cs_ff[SYNC_STAGES-1] &  cs_d;

endmodule

// File: rtl/spi_sram_target.sv
// rtl/spi_sram_target.sv - SPI mode-0 serial SRAM target, oversampled in clk
// Optional SPI_SRAM_STATUS_REG_EN adds RDSR/WRSR and the byte/page/sequential mode register.
module spi_sram_target
  import spi_sram_pkg::*;
#(
  parameter int MEM_AW      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs,
  input  logic       MOSI,
  output logic       MISO,
  output logic       MISO_oe,
  output logic       xfer_done,
  spi_sram_if.master mem
);

  localparam logic [MEM_AW-1:0] PAGE_MASK = MEM_AW'(31);

  state_t            state, state_nxt;
  logic              cs_s, mosi_s, sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [4:0]        bit_cnt;
  logic              last_bit;
  logic [6:0]        shift_in;
  logic [7:0]        rx_byte, shift_out, rd_buf, tx_src;
  logic [MEM_AW-2:0] addr_sr;
  logic [MEM_AW-1:0] addr, wire_addr;
  logic              is_read, done_ok, rd_load, rdsr_active;
  logic [1:0]        mode;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk     (sclk),
    .cs       (cs),
    .mosi     (MOSI),
    .cs_s     (cs_s),
    .mosi_s   (mosi_s),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .cs_rise  (cs_rise),
    .cs_fall  (cs_fall)
  );

  assign rx_byte   = {shift_in, mosi_s};
  assign wire_addr = {addr_sr, mosi_s};
  assign mem.mem_addr = addr;

`ifdef SPI_SRAM_STATUS_REG_EN
  logic [7:0] mode_reg;
  logic       is_wrsr;
  assign mode        = mode_reg[7:6];
  assign rdsr_active = (state == STATUS) && !is_wrsr;
  assign tx_src      = rdsr_active ? mode_reg : rd_buf;
`else
  assign mode        = MODE_SEQ;
  assign rdsr_active = 1'b0;
  assign tx_src      = rd_buf;
`endif

  // Page mode keeps the upper address bits and wraps only addr[4:0]
  function automatic logic [MEM_AW-1:0] addr_step(input logic [MEM_AW-1:0] a, input logic [1:0] m);
    logic [MEM_AW-1:0] inc;
    inc = a + MEM_AW'(1);
    if (m == MODE_PAGE) return (a & ~PAGE_MASK) | (inc & PAGE_MASK);
    return inc;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    last_bit  = (state == ADDR) ? (bit_cnt == 5'd23) : (bit_cnt == 5'd7);
    case (state)
      IDLE: if (cs_fall) state_nxt = CMD;
      CMD: if (sclk_rise && last_bit) begin
        if (is_mem_op(rx_byte)) state_nxt = ADDR;
`ifdef SPI_SRAM_STATUS_REG_EN
        else if (is_status_op(rx_byte)) state_nxt = STATUS;
`endif
        else state_nxt = IGNORE;
      end
      ADDR: if (sclk_rise && last_bit) state_nxt = is_read ? RD_DATA : WR_DATA;
      default: ;
    endcase
    if (cs_s) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt       <= '0;
      shift_in      <= '0;
      shift_out     <= '0;
      rd_buf        <= '0;
      addr_sr       <= '0;
      addr          <= '0;
      is_read       <= 1'b0;
      done_ok       <= 1'b0;
      rd_load       <= 1'b0;
      MISO          <= 1'b0;
      MISO_oe       <= 1'b0;
      xfer_done     <= 1'b0;
      mem.mem_rd_en <= 1'b0;
      mem.mem_wr_en <= 1'b0;
      mem.mem_wdata <= '0;
`ifdef SPI_SRAM_STATUS_REG_EN
      mode_reg      <= MODE_RESET;
      is_wrsr       <= 1'b0;
`endif
    end else begin
      mem.mem_rd_en <= 1'b0;
      mem.mem_wr_en <= 1'b0;
      xfer_done     <= 1'b0;
      rd_load       <= mem.mem_rd_en;
      if (rd_load) rd_buf <= mem.mem_rdata;
      if (mem.mem_wr_en) addr <= addr_step(addr, mode);

      if (cs_s) begin
        bit_cnt   <= '0;
        MISO      <= 1'b0;
        MISO_oe   <= 1'b0;
        done_ok   <= 1'b0;
        xfer_done <= cs_rise && done_ok && (state == RD_DATA || state == WR_DATA);
      end else begin
        if (sclk_rise && state != IDLE) begin
          shift_in <= rx_byte[6:0];
          addr_sr  <= wire_addr[MEM_AW-2:0];
          bit_cnt  <= last_bit ? 5'd0 : bit_cnt + 5'd1;
          case (state)
            CMD: if (last_bit) begin
              is_read <= (rx_byte == OP_READ);
`ifdef SPI_SRAM_STATUS_REG_EN
              is_wrsr <= (rx_byte == OP_WRSR);
`endif
            end
            ADDR: if (last_bit) begin
              addr          <= wire_addr;
              mem.mem_rd_en <= is_read;
            end
            RD_DATA: begin
              // prefetch on the 7th rise so the next byte is ready for the byte-boundary fall
              if (bit_cnt == 5'd6 && mode != MODE_BYTE) begin
                addr          <= addr_step(addr, mode);
                mem.mem_rd_en <= 1'b1;
              end
              if (last_bit) done_ok <= 1'b1;
            end
            WR_DATA: if (last_bit) begin
              if (!(mode == MODE_BYTE && done_ok)) begin
                mem.mem_wr_en <= 1'b1;
                mem.mem_wdata <= rx_byte;
              end
              done_ok <= 1'b1;
            end
`ifdef SPI_SRAM_STATUS_REG_EN
            STATUS: if (last_bit) begin
              if (is_wrsr && !done_ok) mode_reg <= rx_byte;
              done_ok <= 1'b1;
            end
`endif
            default: ;
          endcase
        end

        if (sclk_fall && (state == RD_DATA || rdsr_active)) begin
          MISO_oe <= 1'b1;
          if (bit_cnt == 5'd0) begin
            MISO      <= tx_src[7];
            shift_out <= {tx_src[6:0], 1'b0};
            if (state == RD_DATA && mode == MODE_BYTE) rd_buf <= '0;
          end else begin
            MISO      <= shift_out[7];
            shift_out <= {shift_out[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_sram_target.sv
// tb/tb_spi_sram_target.sv - directed vector bench for spi_sram_target
module tb_spi_sram_target;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic cs = 1'b1;
  logic MOSI = 1'b0;
  logic MISO, MISO_oe, xfer_done;

  always #5 clk = ~clk;

  spi_sram_if #(.MEM_AW(12)) mem_bus ();

  spi_sram_target #(.MEM_AW(12), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk     (sclk),
    .cs       (cs),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .MISO_oe  (MISO_oe),
    .xfer_done(xfer_done),
    .mem      (mem_bus)
  );

  logic [7:0]  mem_arr [0:4095];
  logic [19:0] wr_log [$];
  int rd_cnt = 0;
  int done_cnt = 0;
  int overlap_cnt = 0;

  always @(posedge clk) begin
    if (mem_bus.mem_rd_en) begin
      mem_bus.mem_rdata <= mem_arr[mem_bus.mem_addr];
      rd_cnt <= rd_cnt + 1;
    end
    if (mem_bus.mem_wr_en) begin
      mem_arr[mem_bus.mem_addr] <= mem_bus.mem_wdata;
      wr_log.push_back({mem_bus.mem_addr, mem_bus.mem_wdata});
    end
    if (xfer_done) done_cnt <= done_cnt + 1;
    if (mem_bus.mem_rd_en && mem_bus.mem_wr_en) overlap_cnt <= overlap_cnt + 1;
  end

  int checks = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    int          nbytes;
    logic [47:0] tx;
    int          extra;
    logic [31:0] extra_pat;
    int          exp_nwr;
    logic [19:0] exp_wr0;
    logic [19:0] exp_wr1;
    int          exp_rd;
    int          exp_done;
    int          oe_from;
    int          nrx;
    logic [15:0] exp_rx;
  } vec_t;

  logic miso_s [0:79];
  logic oe_s   [0:79];

  // master samples MISO just before raising sclk; sclk half period is 8 clk
  task automatic spi_bit(input logic b, input int idx);
    MOSI = b;
    repeat (8) @(negedge clk);
    miso_s[idx] = MISO;
    oe_s[idx]   = MISO_oe;
    sclk = 1'b1;
    repeat (8) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int wr0, rd0, dn0, nb, oe_bad;
    logic [15:0] rx;
    logic b;
    wr0 = wr_log.size();
    rd0 = rd_cnt;
    dn0 = done_cnt;
    nb  = v.nbytes * 8 + v.extra;
    @(negedge clk);
    cs = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      if (i < v.nbytes * 8) b = v.tx[47 - i];
      else                  b = v.extra_pat[31 - (i - v.nbytes * 8)];
      spi_bit(b, i);
    end
    repeat (8) @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
    check({v.name, " wr_count"}, wr_log.size() - wr0, v.exp_nwr);
    if (v.exp_nwr > 0) check({v.name, " wr0"}, wr_log[wr0], v.exp_wr0);
    if (v.exp_nwr > 1) check({v.name, " wr1"}, wr_log[wr0 + 1], v.exp_wr1);
    check({v.name, " rd_count"}, rd_cnt - rd0, v.exp_rd);
    check({v.name, " xfer_done"}, done_cnt - dn0, v.exp_done);
    oe_bad = 0;
    for (int i = 0; i < nb; i++)
      if (oe_s[i] !== (i >= v.oe_from)) oe_bad++;
    check({v.name, " oe_bits_wrong"}, oe_bad, 0);
    if (v.nrx > 0) begin
      rx = '0;
      for (int k = 0; k < v.nrx * 8; k++) rx = {rx[14:0], miso_s[v.nbytes * 8 + k]};
      check({v.name, " miso_data"}, rx, v.exp_rx);
    end
  endtask

  vec_t vecs [8];
  vec_t v_extra;
  int   rd0, wr0, dn0, oe_cnt;

  initial begin
    vecs[0] = '{"write",     6, 48'h02_000010_A53C, 0,  32'h0,         2, {12'h010, 8'hA5}, {12'h011, 8'h3C}, 0, 1, 999, 0, 16'h0};
    vecs[1] = '{"read",      4, 48'h03_000010_0000, 16, 32'h0,         0, 20'h0, 20'h0,                       3, 1, 32,  2, 16'hA53C};
    vecs[2] = '{"wrap_wr",   6, 48'h02_000FFF_1122, 0,  32'h0,         2, {12'hFFF, 8'h11}, {12'h000, 8'h22}, 0, 1, 999, 0, 16'h0};
    vecs[3] = '{"ignore",    1, 48'h9F_0000000000,  32, 32'hFFFF_FFFF, 0, 20'h0, 20'h0,                       0, 0, 999, 0, 16'h0};
    vecs[4] = '{"abort",     4, 48'h02_000020_0000, 4,  32'hA000_0000, 0, 20'h0, 20'h0,                       0, 0, 999, 0, 16'h0};
    vecs[5] = '{"after_abt", 5, 48'h02_000020_5A00, 0,  32'h0,         1, {12'h020, 8'h5A}, 20'h0,            0, 1, 999, 0, 16'h0};
    vecs[6] = '{"wrap_rd",   4, 48'h03_ABCFFF_0000, 16, 32'h0,         0, 20'h0, 20'h0,                       3, 1, 32,  2, 16'h1122};
    vecs[7] = '{"addr_only", 3, 48'h03_0000_000000, 0,  32'h0,         0, 20'h0, 20'h0,                       0, 0, 999, 0, 16'h0};

    repeat (4) @(negedge clk);
    check("reset_outputs", {MISO, MISO_oe, xfer_done, mem_bus.mem_rd_en, mem_bus.mem_wr_en,
                            mem_bus.mem_addr, mem_bus.mem_wdata}, 32'h0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // reset in the middle of a read data phase, cs kept low afterwards
    @(negedge clk);
    cs = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 32; i++) spi_bit(((32'h03000010 >> (31 - i)) & 32'h1) != 0, i);
    for (int i = 32; i < 36; i++) spi_bit(1'b0, i);
    check("midrst oe_before", MISO_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst cleared", {MISO, MISO_oe, mem_bus.mem_rd_en, mem_bus.mem_wr_en, mem_bus.mem_addr}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rd0 = rd_cnt;
    wr0 = wr_log.size();
    dn0 = done_cnt;
    oe_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      spi_bit(1'b1, i);
      if (oe_s[i]) oe_cnt++;
    end
    repeat (8) @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst no_oe", oe_cnt, 0);
    check("midrst no_mem", (rd_cnt - rd0) + (wr_log.size() - wr0), 0);
    check("midrst no_done", done_cnt - dn0, 0);
    v_extra = '{"post_rst_rd", 4, 48'h03_000010_0000, 8, 32'h0, 0, 20'h0, 20'h0, 2, 1, 32, 1, 16'h00A5};
    run_vec(v_extra);

`ifdef SPI_SRAM_STATUS_REG_EN
    v_extra = '{"wrsr_00", 2, 48'h01_00_00000000, 0, 32'h0, 0, 20'h0, 20'h0, 0, 0, 999, 0, 16'h0};
    run_vec(v_extra);
    v_extra = '{"byte_wr", 6, 48'h02_000020_AABB, 0, 32'h0, 1, {12'h020, 8'hAA}, 20'h0, 0, 1, 999, 0, 16'h0};
    run_vec(v_extra);
    v_extra = '{"rdsr_00", 1, 48'h05_0000000000, 16, 32'h0, 0, 20'h0, 20'h0, 0, 0, 8, 2, 16'h0000};
    run_vec(v_extra);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    v_extra = '{"rdsr_40", 1, 48'h05_0000000000, 16, 32'h0, 0, 20'h0, 20'h0, 0, 0, 8, 2, 16'h4040};
    run_vec(v_extra);
`else
    v_extra = '{"rdsr_ign", 1, 48'h05_0000000000, 16, 32'hFFFF_0000, 0, 20'h0, 20'h0, 0, 0, 999, 0, 16'h0};
    run_vec(v_extra);
`endif

    check("rd_wr_overlap", overlap_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
